// File: rtl/smc_if.sv
// Handshake/operand bundle for serial_mag_comp.
// master: start, a, b, signed_mode out; busy, done, gt, lt, eq in.
// slave : the comparator side of the same signals.
interface smc_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, gt, lt, eq
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, gt, lt, eq
    );
endinterface

// File: rtl/serial_mag_comp.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, exiting at the first differing digit.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus (slave)  - start/a/b/signed_mode in; busy/done/gt/lt/eq out (registered)
module serial_mag_comp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    smc_if.slave bus
);

    localparam int unsigned NDIG  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject operand/digit combinations that do not split evenly.
    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_mag_comp: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [WIDTH-1:0] msb_flip;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;

    // Flipping both MSBs maps two's-complement to offset binary, so an
    // unsigned digit compare yields the signed ordering.
    assign msb_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};
    assign da       = sa_q[WIDTH-1 -: DIGIT];
    assign db       = sb_q[WIDTH-1 -: DIGIT];

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a ^ msb_flip;
                    sb_d    = bus.b ^ msb_flip;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (da > db) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (da < db) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(NDIG - 1)) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
    assign bus.eq   = eq_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: WIDTH=8 vectors at DIGIT 1 and 4 with a
// scoreboard, hand sequences for ignored starts and mid-run reset, and an
// exhaustive WIDTH=4 sweep for DIGIT 1, 2, 4.
module tb_serial_mag_comp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_sw_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic        sel;
        logic [2:0]  flags;   // {gt, lt, eq}
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic [2:0]  flags;
        int unsigned lat;
    } exp_t;

    // WIDTH=8 DUTs sharing operand drivers; sel picks which gets start.
    logic       start = 1'b0;
    logic [7:0] a_v = '0;
    logic [7:0] b_v = '0;
    logic       sm = 1'b0;
    logic       sel = 1'b0;

    smc_if #(.WIDTH(8)) if1 ();
    smc_if #(.WIDTH(8)) if4 ();

    assign if1.start       = start & ~sel;
    assign if4.start       = start & sel;
    assign if1.a           = a_v;
    assign if4.a           = a_v;
    assign if1.b           = b_v;
    assign if4.b           = b_v;
    assign if1.signed_mode = sm;
    assign if4.signed_mode = sm;

    serial_mag_comp #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_mag_comp #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    logic m_busy, m_done, m_gt, m_lt, m_eq;
    assign m_busy = sel ? if4.busy : if1.busy;
    assign m_done = sel ? if4.done : if1.done;
    assign m_gt   = sel ? if4.gt   : if1.gt;
    assign m_lt   = sel ? if4.lt   : if1.lt;
    assign m_eq   = sel ? if4.eq   : if1.eq;

    exp_t        sb_q[$];
    int unsigned start_cyc = 0;
    int unsigned busy_cnt = 0;
    logic        flags_clean = 1'b1;

    // Scoreboard monitor for the WIDTH=8 DUTs.
    always @(negedge clk) begin
        if (m_busy) begin
            busy_cnt++;
            if ({m_gt, m_lt, m_eq} != 3'b000) flags_clean = 1'b0;
        end
        if (m_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_done: done=1 with no compare pending (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("flags", 32'({m_gt, m_lt, m_eq}), 32'(e.flags));
                check("latency", cyc - start_cyc, e.lat);
                check("busy_cycles", busy_cnt, e.lat);
                check("flags_zero_while_busy", 32'(flags_clean), 32'd1);
            end
        end
    end

    task automatic launch(input vec_t v);
        @(negedge clk);
        sel = v.sel; a_v = v.a; b_v = v.b; sm = v.sm; start = 1'b1;
        sb_q.push_back('{v.flags, v.lat});
        start_cyc = cyc + 1;
        busy_cnt = 0;
        flags_clean = 1'b1;
    endtask

    task automatic wait_result(input string name);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no done within 20 cycles", name);
            sb_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        launch(v);
        @(negedge clk); #1;
        start = 1'b0;
        // Operand changes after the start edge must not disturb the compare.
        a_v = 8'($urandom); b_v = 8'($urandom); sm = 1'($urandom);
        wait_result("run");
        @(negedge clk); #1;
        check("done_one_cycle", 32'(m_done), 32'd0);
        check("idle_not_busy", 32'(m_busy), 32'd0);
        check("result_hold", 32'({m_gt, m_lt, m_eq}), 32'(v.flags));
    endtask

    // Exhaustive WIDTH=4 sweeps, one per DIGIT.
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int unsigned D  = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int unsigned ND = 4 / D;
        smc_if #(.WIDTH(4)) sif ();
        serial_mag_comp #(.WIDTH(4), .DIGIT(D)) dut (.clk(clk), .rst_n(rst_sw_n), .bus(sif));
        exp_t q[$];
        logic fin = 1'b0;

        initial begin
            sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.signed_mode = 1'b0;
            wait (rst_sw_n);
            for (int s = 0; s < 2; s++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        logic signed [3:0] xs, ys;
                        logic [3:0] dx;
                        exp_t e;
                        int unsigned t0;
                        bit found;
                        xs = 4'(x); ys = 4'(y);
                        if (s == 1) e.flags = {xs > ys, xs < ys, xs == ys};
                        else        e.flags = {x > y, x < y, x == y};
                        dx = 4'(x ^ y);
                        e.lat = ND;
                        found = 1'b0;
                        for (int k = 0; k < int'(ND); k++) begin
                            if (!found && ((dx >> (4 - (k + 1) * D)) & 4'((1 << D) - 1)) != 4'd0) begin
                                e.lat = k + 1;
                                found = 1'b1;
                            end
                        end
                        @(negedge clk);
                        sif.a = 4'(x); sif.b = 4'(y); sif.signed_mode = 1'(s); sif.start = 1'b1;
                        q.push_back(e);
                        t0 = cyc + 1;
                        @(negedge clk);
                        sif.start = 1'b0;
                        for (int i = 0; i < 10 && !sif.done; i++) @(negedge clk);
                        if (sif.done) begin
                            exp_t r;
                            r = q.pop_front();
                            check($sformatf("sweep_d%0d_flags_%0d_%0h_%0h", D, s, x, y),
                                  32'({sif.gt, sif.lt, sif.eq}), 32'(r.flags));
                            check($sformatf("sweep_d%0d_lat_%0d_%0h_%0h", D, s, x, y),
                                  cyc - t0, r.lat);
                        end else begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL sweep_d%0d_timeout: a=%0h b=%0h", D, x, y);
                            q.delete();
                        end
                    end
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        vec_t vt[9];
        vt[0] = '{8'hA5, 8'h25, 1'b0, 1'b0, 3'b100, 1};
        vt[1] = '{8'h3C, 8'h3C, 1'b0, 1'b0, 3'b001, 8};
        vt[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 3'b010, 1};
        vt[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 3'b100, 1};
        vt[4] = '{8'h10, 8'h11, 1'b0, 1'b0, 3'b010, 8};
        vt[5] = '{8'h5A, 8'h5B, 1'b0, 1'b1, 3'b010, 2};
        vt[6] = '{8'h80, 8'h7F, 1'b1, 1'b1, 3'b010, 1};
        vt[7] = '{8'h7F, 8'h80, 1'b1, 1'b1, 3'b100, 1};
        vt[8] = '{8'hC3, 8'hC3, 1'b1, 1'b1, 3'b001, 2};

        #12;
        check("reset_outputs_d1", 32'({if1.busy, if1.done, if1.gt, if1.lt, if1.eq}), 32'd0);
        check("reset_outputs_d4", 32'({if4.busy, if4.done, if4.gt, if4.lt, if4.eq}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rst_sw_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // Starts while busy and in DONE are ignored.
        launch('{8'h10, 8'h11, 1'b0, 1'b0, 3'b010, 8});
        @(negedge clk); #1;
        a_v = 8'hFF; b_v = 8'h00;          // start stays high across E1, E2
        @(negedge clk); #1;
        start = 1'b0;
        wait_result("ignore");
        start = 1'b1;                      // sampled while in DONE
        @(negedge clk); #1;
        check("done_start_ignored_done", 32'(m_done), 32'd0);
        check("done_start_ignored_busy", 32'(m_busy), 32'd0);
        check("done_start_ignored_flags", 32'({m_gt, m_lt, m_eq}), 32'b010);
        start = 1'b0;
        @(negedge clk); #1;
        check("no_restart", 32'(m_busy), 32'd0);
        run_vec('{8'hFF, 8'h00, 1'b0, 1'b0, 3'b100, 1});

        // Reset in the middle of a compare.
        launch('{8'h10, 8'h11, 1'b0, 1'b0, 3'b010, 8});
        @(negedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("busy_before_reset", 32'(m_busy), 32'd1);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrun_reset_outputs", 32'({if1.busy, if1.done, if1.gt, if1.lt, if1.eq}), 32'd0);
        @(negedge clk); #1;
        check("reset_no_done", 32'(m_done), 32'd0);
        rst_n = 1'b1;
        run_vec('{8'h10, 8'h11, 1'b0, 1'b0, 3'b010, 8});

        for (int i = 0; i < 40000 && !(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin); i++)
            @(negedge clk);
        if (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin)) begin
            n_checks++;
            n_errors++;
            $display("FAIL sweep_timeout: sweeps finished=%b expected 111",
                     {g_sw[2].fin, g_sw[1].fin, g_sw[0].fin});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
